// File: rtl/chase_pkg.sv
// rtl/chase_pkg.sv - shared types, defaults and saturation helper for the chase drive controller
package chase_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEARCH   = 3'd1,
    APPROACH = 3'd2,
    HOLD     = 3'd3
  } drive_state_t;

  typedef logic signed [8:0]  speed_t;
  typedef logic signed [10:0] wide_t;

  localparam int IMG_CENTER_X_DEF = 160;
  localparam int MAX_SPEED_DEF    = 120;

  function automatic wide_t sat(input wide_t v, input wide_t lim);
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

endpackage

// File: rtl/ramp_limiter.sv
// rtl/ramp_limiter.sv - moves a wheel speed toward its target by at most one step per frame
module ramp_limiter
  import chase_pkg::*;
(
  input  wide_t  target_i,
  input  speed_t current_i,
  input  wide_t  step_i,
  output speed_t next_o
);

  wide_t cur;
  wide_t diff;
  wide_t nxt;

  always_comb begin
    cur  = wide_t'(current_i);
    diff = target_i - cur;
    if (diff > step_i)       nxt = cur + step_i;
    else if (diff < -step_i) nxt = cur - step_i;
    else                     nxt = target_i;
    next_o = speed_t'(nxt);
  end

endmodule

// File: rtl/chase_drive_ctrl.sv
// rtl/chase_drive_ctrl.sv - frame-rate search/approach/hold/lost drive FSM with slew-limited wheel speeds
module chase_drive_ctrl
  import chase_pkg::*;
#(
  parameter int IMG_CENTER_X = IMG_CENTER_X_DEF,
  parameter int DEADBAND     = 8,
  parameter int KP_SHIFT     = 2,
  parameter int BASE_SPEED   = 64,
  parameter int MAX_SPEED    = MAX_SPEED_DEF,
  parameter int RAMP_STEP    = 8,
  parameter int SEARCH_SPEED = 40,
  parameter int RAD_TOL      = 4,
  parameter int LOST_FRAMES  = 15
) (
  input  logic       clk_65mhz,
  input  logic       reset_n,
  input  logic       frame_done,
  input  logic       track,
  input  logic       move,
  input  logic       blob_valid,
  input  logic [8:0] blob_x,
  input  logic [6:0] blob_rad,
  input  logic [6:0] goal_rad,
  output speed_t     speed1,
  output speed_t     speed2,
  output logic [2:0] drive_state,
  output logic       lost
);

  localparam int              CW     = $clog2(LOST_FRAMES + 1);
  localparam logic [CW-1:0]   LOST_C = CW'(LOST_FRAMES);

  drive_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  wide_t         tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  speed_t        s1_q, s2_q, s1_next, s2_next;

  wide_t      err_raw, err, turn, fwd, calc1, calc2;
  logic [7:0] rad_plus, goal_plus;

  always_comb begin
    err_raw   = wide_t'({2'b00, blob_x}) - wide_t'(IMG_CENTER_X);
    err       = ((err_raw <= wide_t'(DEADBAND)) && (err_raw >= -wide_t'(DEADBAND))) ? '0 : err_raw;
    turn      = err >>> KP_SHIFT;
    rad_plus  = {1'b0, blob_rad} + 8'(RAD_TOL);
    goal_plus = {1'b0, goal_rad} + 8'(RAD_TOL);
    if (rad_plus < {1'b0, goal_rad})       fwd = wide_t'(BASE_SPEED);
    else if ({1'b0, blob_rad} > goal_plus) fwd = -wide_t'(BASE_SPEED >> 1);
    else                                   fwd = '0;
    calc1   = sat(fwd + turn, wide_t'(MAX_SPEED));
    calc2   = sat(fwd - turn, wide_t'(MAX_SPEED));
    cnt_inc = (cnt_q == LOST_C) ? cnt_q : cnt_q + 1'b1;
  end

  // Targets are chosen for the state being entered; a missing blob coasts on the last target.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt1_d  = tgt1_q;
    tgt2_d  = tgt2_q;
    if (!track || (frame_done && !move)) begin
      state_d = IDLE;
      cnt_d   = '0;
      tgt1_d  = '0;
      tgt2_d  = '0;
    end else if (frame_done) begin
      if (blob_valid) begin
        cnt_d = '0;
        if ((state_q == APPROACH || state_q == HOLD) && fwd == '0 && err == '0) begin
          state_d = HOLD;
          tgt1_d  = '0;
          tgt2_d  = '0;
        end else begin
          state_d = APPROACH;
          tgt1_d  = calc1;
          tgt2_d  = calc2;
        end
      end else begin
        cnt_d = cnt_inc;
        if (state_q == IDLE || state_q == SEARCH || cnt_inc == LOST_C) begin
          state_d = SEARCH;
          tgt1_d  = wide_t'(SEARCH_SPEED);
          tgt2_d  = -wide_t'(SEARCH_SPEED);
        end
      end
    end
  end

  ramp_limiter u_ramp1 (
    .target_i  (tgt1_d),
    .current_i (s1_q),
    .step_i    (wide_t'(RAMP_STEP)),
    .next_o    (s1_next)
  );

  ramp_limiter u_ramp2 (
    .target_i  (tgt2_d),
    .current_i (s2_q),
    .step_i    (wide_t'(RAMP_STEP)),
    .next_o    (s2_next)
  );

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt1_q  <= '0;
      tgt2_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      if (!track) begin
        s1_q <= '0;
        s2_q <= '0;
      end else if (frame_done) begin
        s1_q <= s1_next;
        s2_q <= s2_next;
      end
    end
  end

  assign speed1      = s1_q;
  assign speed2      = s2_q;
  assign drive_state = state_q;
  assign lost        = (cnt_q == LOST_C);

endmodule
